uart_rx_deser: RTL and testbench



---
 rtl/uart_rx_deser.sv | 146 ++++++++++++++
 tb/tb_uart_rx_deser.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, start-glitch rejection
// and stop-bit framing check; emits a byte with a one-cycle valid strobe.
module uart_rx_deser #(
   parameter int CLKS_PER_BIT = 104,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rx_i,
   output logic [7:0] rx_data,
   output logic       new_rx_data,
   output logic       frame_err_o,
   output logic       rx_busy_o
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_e;

   state_e             state_q, state_d;
   logic               sync1_q, sync1_d;
   logic               rx_s_q, rx_s_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [7:0]         shift_q, shift_d;
   logic [7:0]         rx_data_q, rx_data_d;
   logic               new_rx_data_q, new_rx_data_d;
   logic               frame_err_q, frame_err_d;

   logic               half_hit;
   logic               full_hit;

   assign half_hit = (cnt_q == CNT_W'(HALF_BIT - 1));
   assign full_hit = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

   // The synchronizer idles high so reset never looks like a start bit.
   assign sync1_d = rx_i;
   assign rx_s_d  = sync1_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path can leave it unassigned (no latch).
      state_d       = state_q;
      cnt_d         = cnt_q + CNT_W'(1);
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      rx_data_d     = rx_data_q;
      new_rx_data_d = 1'b0;
      frame_err_d   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end

         START: begin
            if (half_hit) begin
               cnt_d = '0;
               if (!rx_s_q) begin
                  state_d   = DATA;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         DATA: begin
            if (full_hit) begin
               shift_d   = {rx_s_q, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               cnt_d     = '0;
               if (bit_idx_q == 3'd7) begin
                  state_d = STOP;
               end
            end
         end

         // Leaving STOP at mid-bit lets a start bit directly after the stop bit be caught.
         STOP: begin
            if (full_hit) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  rx_data_d     = shift_q;
                  new_rx_data_d = 1'b1;
                  state_d       = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_IDLE;
               end
            end
         end

         WAIT_IDLE: begin
            if (rx_s_q) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q       <= 1'b1;
         rx_s_q        <= 1'b1;
         state_q       <= IDLE;
         cnt_q         <= '0;
         bit_idx_q     <= 3'd0;
         shift_q       <= 8'h00;
         rx_data_q     <= 8'h00;
         new_rx_data_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         rx_s_q        <= rx_s_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         rx_data_q     <= rx_data_d;
         new_rx_data_q <= new_rx_data_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign rx_data     = rx_data_q;
   assign new_rx_data = new_rx_data_q;
   assign frame_err_o = frame_err_q;
   assign rx_busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: stimulus pushes expected bytes/errors into a
// scoreboard queue; a monitor pops and compares whenever the DUT pulses.
`timescale 1ns/1ps
module tb_uart_rx_deser;

   localparam int BIT = 104;
   localparam int LAT = 2 + BIT / 2 + 9 * BIT + 1;  // 991

   typedef struct {
      logic       is_err;
      logic [7:0] data;
      int         exp_cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstn;
   logic       rx_i;
   logic [7:0] rx_data;
   logic       new_rx_data;
   logic       frame_err_o;
   logic       rx_busy_o;

   int         n_vec = 0;
   int         n_miss = 0;
   int         cyc = 0;
   logic [7:0] exp_last = 8'h00;
   exp_t       sb[$];

   uart_rx_deser dut (
      .clk        (clk),
      .rstn       (rstn),
      .rx_i       (rx_i),
      .rx_data    (rx_data),
      .new_rx_data(new_rx_data),
      .frame_err_o(frame_err_o),
      .rx_busy_o  (rx_busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic check_range(input string name, input int got, input int lo, input int hi);
      n_vec++;
      if (got < lo || got > hi) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
      end
   endtask

   task automatic bit_time();
      repeat (BIT) @(negedge clk);
   endtask

   // Called at a negedge; the start edge is the current cycle.
   task automatic send_byte(input logic [7:0] d, input logic stop);
      exp_t e;
      e.is_err  = ~stop;
      e.data    = stop ? d : exp_last;
      e.exp_cyc = cyc + LAT;
      sb.push_back(e);
      if (stop) exp_last = d;
      rx_i = 1'b0;
      bit_time();
      for (int i = 0; i < 8; i++) begin
         rx_i = d[i];
         bit_time();
      end
      rx_i = stop;
      bit_time();
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rstn === 1'b1 && (new_rx_data === 1'b1 || frame_err_o === 1'b1)) begin
         check("pulse_exclusive", {31'b0, new_rx_data & frame_err_o}, 32'd0);
         if (sb.size() == 0) begin
            check("unexpected_pulse", sb.size(), 32'd1);
         end else begin
            e = sb.pop_front();
            check("pulse_kind_is_err", {31'b0, frame_err_o}, {31'b0, e.is_err});
            check("rx_data", {24'b0, rx_data}, {24'b0, e.data});
            check_range("pulse_cycle", cyc, e.exp_cyc - 1, e.exp_cyc + 1);
         end
      end
   end

   initial begin
      int   busy_cnt;
      exp_t e;

      rstn = 1'b0;
      rx_i = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_rx_data", {24'b0, rx_data}, 32'h00);
      check("reset_new_rx_data", {31'b0, new_rx_data}, 32'd0);
      check("reset_frame_err", {31'b0, frame_err_o}, 32'd0);
      check("reset_busy", {31'b0, rx_busy_o}, 32'd0);
      rstn = 1'b1;
      bit_time();

      // Single byte
      send_byte(8'hA5, 1'b1);
      bit_time();
      bit_time();

      // Back-to-back, no idle gap
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h55, 1'b1);
      bit_time();
      bit_time();

      // Glitch rejection: 30-cycle low pulse
      busy_cnt = 0;
      rx_i = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (i == 30) rx_i = 1'b1;
         @(negedge clk);
         if (rx_busy_o) busy_cnt++;
      end
      check_range("glitch_busy_cycles", busy_cnt, 51, 53);
      check("glitch_rx_data", {24'b0, rx_data}, 32'h55);
      bit_time();

      // Framing error then a good byte
      send_byte(8'h3C, 1'b0);
      bit_time();
      rx_i = 1'b1;
      bit_time();
      bit_time();
      send_byte(8'h81, 1'b1);
      bit_time();
      bit_time();

      // Break: 30 bit times low
      e.is_err  = 1'b1;
      e.data    = exp_last;
      e.exp_cyc = cyc + LAT;
      sb.push_back(e);
      rx_i = 1'b0;
      repeat (30) bit_time();
      rx_i = 1'b1;
      bit_time();
      bit_time();
      send_byte(8'h42, 1'b1);
      bit_time();
      bit_time();

      // Reset during bit 4 of 0x99
      begin
         logic [7:0] d;
         d = 8'h99;
         rx_i = 1'b0;
         bit_time();
         for (int i = 0; i < 4; i++) begin
            rx_i = d[i];
            bit_time();
         end
         rx_i = d[4];
         repeat (50) @(negedge clk);
      end
      rstn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_mid_rx_data", {24'b0, rx_data}, 32'h00);
         check("rst_mid_new_rx_data", {31'b0, new_rx_data}, 32'd0);
         check("rst_mid_frame_err", {31'b0, frame_err_o}, 32'd0);
         check("rst_mid_busy", {31'b0, rx_busy_o}, 32'd0);
      end
      rx_i = 1'b1;
      rstn = 1'b1;
      exp_last = 8'h00;
      repeat (3) bit_time();
      send_byte(8'h7E, 1'b1);

      for (int i = 0; i < 3000 && sb.size() > 0; i++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      repeat (2 * BIT) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
